rpsc_fault_latch: RTL and testbench
===================================

RPSC_FAULT_LATCH -- requirements
Module: rpsc_fault_latch

Upstream stage of RPSC card 5. Filters and latches raw fault lines into the FF1..FF6 flip-flop levels that card 5 consumes. Card 5 uses them for Not_Alarm, RF permit and RF reduce.

Interface
REQ-001 Parameter FILTER_CYCLES, default 16: consecutive synchronized-high cycles required before a fault latches; legal range 1..255.
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_Fault_Raw  input  6  raw fault lines, active-high, asynchronous to clk; bit k drives FF(k+1).
REQ-005 i_Not_Fault_Reset  input  1  operator reset pushbutton, active-low, asynchronous.
REQ-006 o_FF  output  6  latched fault levels; bit k = FF(k+1), to card 5 FF inputs.
REQ-007 o_Any_Fault  output  1  OR of o_FF, registered with o_FF.
REQ-008 o_First_Fault  output  3  first-fault code: 0 = none, k+1 = channel k.
REQ-009 o_State  output  2  state machine state, for diagnostics.

Function
REQ-010 i_Fault_Raw and i_Not_Fault_Reset SHALL each pass through a 2-flop synchronizer before any use.
REQ-011 Per channel, a saturating counter of width clog2(FILTER_CYCLES+1):
- increments each cycle the synchronized input is high;
- clears to 0 in any cycle the synchronized input is low.
REQ-012 The channel is "qualified" while its counter equals FILTER_CYCLES.
- Raw high sampled at edge 0 and held gives o_FF[k] = 1 after edge FILTER_CYCLES+2.
REQ-013 A raw pulse shorter than FILTER_CYCLES cycles after synchronization SHALL NOT set o_FF.
REQ-014 o_FF[k] SHALL set when channel k is qualified and hold regardless of the raw input until cleared per REQ-016.
REQ-015 A reset press is a falling edge of synchronized i_Not_Fault_Reset. Exactly one clear event per press; holding the button SHALL NOT repeat the clear.
REQ-016 On a clear event, each o_FF[k] whose channel is not qualified SHALL clear on the next edge. Qualified channels stay set.
REQ-017 If a channel qualifies in the same cycle as a clear event, set SHALL win.
REQ-018 State machine (rpsc_pkg enum):
- NORMAL (0): o_FF == 0.
- TRIPPED (1): o_FF != 0.
- CLEAR_HOLD (2): entered on a clear event; remains until synchronized reset is high, then goes to NORMAL if o_FF == 0, else TRIPPED.
- NORMAL -> TRIPPED on any latch set.
- A latch set during CLEAR_HOLD SHALL be accepted; the state stays CLEAR_HOLD.
REQ-019 Clear events SHALL only be generated from NORMAL or TRIPPED.

Reset
REQ-020 On rst_n low, immediately and asynchronously:
- o_FF = 0, o_Any_Fault = 0, o_First_Fault = 0, o_State = NORMAL;
- all counters = 0;
- synchronizers: fault stages = 0, reset stages = 1 (released).
REQ-021 Reset mid-filter SHALL discard partial counts. After release, a fault requires the full FILTER_CYCLES+2 latency.

Configuration
REQ-022 Macro RPSC_FIRST_FAULT_EN defined: o_First_Fault captures k+1 of the first latch to set while o_FF == 0 (lowest index on simultaneous sets). It holds until o_FF returns to 0, then reads 0.
REQ-023 Macro not defined: o_First_Fault SHALL be constant 0 and no capture register SHALL be inferred.

Structure
REQ-024 Package rpsc_pkg SHALL hold:
- NUM_FF = 6;
- the state enum (NORMAL, TRIPPED, CLEAR_HOLD);
- FIRST_FAULT_NONE = 3'd0.
REQ-025 Sub-module rpsc_debounce (synchronizer, counter, qualified flag) SHALL be instanced NUM_FF times. Latches, state machine and first-fault logic live in the top.

Verification (FILTER_CYCLES = 4)
REQ-026 i_Fault_Raw = 6'b000001 held from edge 0 -> o_FF = 6'b000001 and o_Any_Fault = 1 after edge 6, o_State = TRIPPED, o_First_Fault = 1 (macro on).
REQ-027 Bit 2 raw pulse of 3 cycles -> o_FF stays 0 and o_State stays NORMAL.
REQ-028 Latch bit 0, drop raw, press and hold reset 20 cycles -> o_FF = 0 three edges after press, o_State = CLEAR_HOLD until release, then NORMAL. Exactly one clear.
REQ-029 Bits 1 and 4 latched, bit 4 raw still high, press reset -> o_FF = 6'b010000, o_First_Fault unchanged, state returns to TRIPPED.
REQ-030 Bit 3 qualifies in the exact cycle of the clear event -> o_FF[3] = 1 after that edge.
REQ-031 rst_n asserted mid-count (counter = 3) -> all outputs 0 immediately. After release, the fault latches only after 6 further edges.

Source files
------------

// File: rtl/rpsc_fault_latch_pkg.sv
// rpsc_pkg: shared constants, state encoding and first-fault encoder for the RPSC fault latch
package rpsc_pkg;
  localparam int NUM_FF = 6;
  localparam logic [2:0] FIRST_FAULT_NONE = 3'd0;
  typedef enum logic [1:0] {NORMAL = 2'd0, TRIPPED = 2'd1, CLEAR_HOLD = 2'd2} state_t;
  function automatic logic [2:0] first_code(input logic [NUM_FF-1:0] v);
    logic [2:0] c;
    c = FIRST_FAULT_NONE;
    for (int k = NUM_FF - 1; k >= 0; k--) c = v[k] ? 3'(k + 1) : c;
    return c;
  endfunction
endpackage

// File: rtl/rpsc_fault_latch_if.sv
// rpsc_fault_latch_if: raw fault / reset-button inputs and latched fault outputs of the RPSC fault latch
interface rpsc_fault_latch_if;
  import rpsc_pkg::*;
  logic [NUM_FF-1:0] i_Fault_Raw;
  logic              i_Not_Fault_Reset;
  logic [NUM_FF-1:0] o_FF;
  logic              o_Any_Fault;
  logic [2:0]        o_First_Fault;
  state_t            o_State;
  modport master (output i_Fault_Raw, i_Not_Fault_Reset, input o_FF, o_Any_Fault, o_First_Fault, o_State);
  modport slave (input i_Fault_Raw, i_Not_Fault_Reset, output o_FF, o_Any_Fault, o_First_Fault, o_State);
endinterface

// File: rtl/rpsc_debounce.sv
// rpsc_debounce: 2-flop synchronizer plus saturating run-length counter; qual is high once FILTER_CYCLES consecutive highs are seen
module rpsc_debounce #(
  parameter int FILTER_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic qual
);
  localparam int W = $clog2(FILTER_CYCLES + 1);
  localparam logic [W-1:0] LIM = W'(FILTER_CYCLES);
  logic s1, s2;
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
    end else begin
      s1  <= raw;
      s2  <= s1;
      cnt <= !s2 ? '0 : cnt == LIM ? cnt : cnt + W'(1);
    end
  end
  assign qual = cnt == LIM;
endmodule

// File: rtl/rpsc_fault_latch.sv
// rpsc_fault_latch: filtered fault latches with operator clear and state machine; define RPSC_FIRST_FAULT_EN to enable first-fault capture
module rpsc_fault_latch
  import rpsc_pkg::*;
#(
  parameter int FILTER_CYCLES = 16
) (
  input logic clk,
  input logic rst_n,
  rpsc_fault_latch_if.slave bus
);
  logic [NUM_FF-1:0] qual, ff, ff_next;
  logic rst_s1, rst_s2, rst_s3, clr, any_q;
  state_t state, state_next;
  genvar k;
  for (k = 0; k < NUM_FF; k++) begin : g_ch
    rpsc_debounce #(.FILTER_CYCLES(FILTER_CYCLES)) u_db (
      .clk (clk),
      .rst_n(rst_n),
      .raw (bus.i_Fault_Raw[k]),
      .qual(qual[k])
    );
  end
  // One clear per press: falling edge of the synchronized button, never while already holding
  always_comb begin
    clr        = rst_s3 & ~rst_s2 & (state != CLEAR_HOLD);
    ff_next    = clr ? qual : ff | qual;
    state_next = clr ? CLEAR_HOLD :
                 state == CLEAR_HOLD ? (rst_s2 ? (|ff_next ? TRIPPED : NORMAL) : CLEAR_HOLD) :
                 |ff_next ? TRIPPED : NORMAL;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_s1 <= 1'b1;
      rst_s2 <= 1'b1;
      rst_s3 <= 1'b1;
      ff     <= '0;
      any_q  <= 1'b0;
      state  <= NORMAL;
    end else begin
      rst_s1 <= bus.i_Not_Fault_Reset;
      rst_s2 <= rst_s1;
      rst_s3 <= rst_s2;
      ff     <= ff_next;
      any_q  <= |ff_next;
      state  <= state_next;
    end
  end
`ifdef RPSC_FIRST_FAULT_EN
  logic [2:0] first;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) first <= FIRST_FAULT_NONE;
    else first <= ~|ff_next ? FIRST_FAULT_NONE : ~|ff ? first_code(ff_next) : first;
  end
  assign bus.o_First_Fault = first;
`else
  assign bus.o_First_Fault = FIRST_FAULT_NONE;
`endif
  assign bus.o_FF        = ff;
  assign bus.o_Any_Fault = any_q;
  assign bus.o_State     = state;
endmodule

// File: tb/tb_rpsc_fault_latch.sv
// tb_rpsc_fault_latch: randomized + directed scoreboard bench against a sample-history reference model
module tb_rpsc_fault_latch;
  import rpsc_pkg::*;
  localparam int F = 4;
  localparam int N = 2048;
  typedef struct packed {
    logic [5:0] ff;
    logic       any;
    logic [2:0] first;
    logic [1:0] st;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  rpsc_fault_latch_if bus ();
  rpsc_fault_latch #(.FILTER_CYCLES(F)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  exp_t q[$];
  int errors = 0, checks = 0;
  logic [5:0] raw_h[N];
  logic nr_h[N];
  int e = 0, base = 0;
  logic [5:0] m_ff = '0;
  logic [2:0] m_first = '0;
  int m_st = 0;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask
  // Samples taken before the last reset behave as idle inputs
  function automatic logic fh(input int n, input int k);
    return n < base ? 1'b0 : raw_h[n][k];
  endfunction
  function automatic logic rh(input int n);
    return n < base ? 1'b1 : nr_h[n];
  endfunction
  task automatic step(input logic [5:0] raw, input logic nr);
    logic [5:0] qv, nff;
    logic clr;
    exp_t x;
    @(negedge clk);
    if (!rst_n) begin
      rst_n = 1'b1;
      base = e;
    end
    bus.i_Fault_Raw = raw;
    bus.i_Not_Fault_Reset = nr;
    raw_h[e] = raw;
    nr_h[e] = nr;
    for (int k = 0; k < 6; k++) begin
      qv[k] = 1'b1;
      for (int j = 3; j <= F + 2; j++) qv[k] = qv[k] & fh(e - j, k);
    end
    clr = rh(e - 3) && !rh(e - 2) && m_st != 2;
    nff = clr ? qv : (m_ff | qv);
    if (nff == 0) m_first = 3'd0;
    else if (m_ff == 0) for (int k = 5; k >= 0; k--) if (nff[k]) m_first = 3'(k + 1);
    m_st = clr ? 2 : (m_st == 2 && !rh(e - 2)) ? 2 : (nff != 0 ? 1 : 0);
    m_ff = nff;
    x.ff = m_ff;
    x.any = |m_ff;
`ifdef RPSC_FIRST_FAULT_EN
    x.first = m_first;
`else
    x.first = 3'd0;
`endif
    x.st = 2'(m_st);
    q.push_back(x);
    e++;
  endtask
  task automatic check_zero();
    chk("reset o_FF", 8'(bus.o_FF), 8'd0);
    chk("reset o_Any_Fault", 8'(bus.o_Any_Fault), 8'd0);
    chk("reset o_First_Fault", 8'(bus.o_First_Fault), 8'd0);
    chk("reset o_State", 8'(bus.o_State), 8'(NORMAL));
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero();
    m_ff = '0;
    m_first = '0;
    m_st = 0;
  endtask
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("o_FF", 8'(bus.o_FF), 8'(x.ff));
        chk("o_Any_Fault", 8'(bus.o_Any_Fault), 8'(x.any));
        chk("o_First_Fault", 8'(bus.o_First_Fault), 8'(x.first));
        chk("o_State", 8'(bus.o_State), 8'(x.st));
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic [5:0] r;
    logic nr;
    bus.i_Fault_Raw = '0;
    bus.i_Not_Fault_Reset = 1'b1;
    #1 check_zero();
    repeat (3) step(6'h00, 1);
    repeat (10) step(6'h01, 1);
    repeat (3) step(6'h00, 1);
    repeat (20) step(6'h00, 0);
    repeat (6) step(6'h00, 1);
    repeat (3) step(6'h04, 1);
    repeat (8) step(6'h00, 1);
    repeat (8) step(6'h12, 1);
    repeat (3) step(6'h10, 1);
    repeat (4) step(6'h10, 0);
    repeat (6) step(6'h10, 1);
    repeat (3) step(6'h00, 1);
    repeat (2) step(6'h00, 0);
    repeat (6) step(6'h00, 1);
    for (int i = 0; i < F + 6; i++) step(6'h08, i >= F && i < F + 3 ? 1'b0 : 1'b1);
    repeat (3) step(6'h00, 1);
    repeat (3) step(6'h00, 0);
    repeat (6) step(6'h00, 1);
    repeat (8) step(6'h01, 1);
    repeat (5) step(6'h20, 1);
    do_reset();
    repeat (10) step(6'h20, 1);
    r = '0;
    nr = 1'b1;
    repeat (700) begin
      for (int k = 0; k < 6; k++) if ($urandom_range(0, 9) == 0) r[k] = ~r[k];
      if ($urandom_range(0, 11) == 0) nr = ~nr;
      step(r, nr);
    end
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard drained", 8'(q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
